// File: rtl/mmcm_lock_sequencer.sv
// mmcm_lock_sequencer: MMCM bring-up sequencer (reset pulse, lock wait
// with timeout, lock settle, retries) that gates the downstream reset.
//
// Ports:
//   CLK100MHZ     in   free-running clock, all logic on rising edge
//   reset         in   synchronous active-high reset, highest priority
//   restart       in   1-cycle request to re-run the whole sequence
//   locked        in   MMCM LOCKED, asynchronous, synchronized here
//   mmcm_rst      out  MMCM RST, active-high
//   sys_rst       out  downstream synchronous reset, active-high
//   ready         out  high only in RUN
//   fault         out  high only in FAULT
//   retry_count   out  failed attempts in the current sequence
//   lock_loss_cnt out  saturating count of lock drops seen in RUN
//
// Optional feature macro: MMCM_AUTO_RELOCK_EN
//   defined   -> lock loss in RUN re-runs the sequence automatically
//   undefined -> lock loss in RUN parks in FAULT until restart/reset
module mmcm_lock_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 100000,
    parameter int SETTLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                               CLK100MHZ,
    input  logic                               reset,
    input  logic                               restart,
    input  logic                               locked,
    output logic                               mmcm_rst,
    output logic                               sys_rst,
    output logic                               ready,
    output logic                               fault,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
    output logic [7:0]                         lock_loss_cnt
);

    localparam int RCW  = $clog2(MAX_RETRIES + 1);
    localparam int MAX1 = (LOCK_TIMEOUT > SETTLE_CYCLES) ?
                          LOCK_TIMEOUT : SETTLE_CYCLES;
    localparam int MAXC = (MAX1 > RST_CYCLES) ? MAX1 : RST_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0]  RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0]  TO_LAST  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0]  SET_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [RCW-1:0] RC_MAX   = RCW'(MAX_RETRIES);

    localparam logic [2:0] S_RST_HOLD  = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_SETTLE    = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_FAULT     = 3'd4;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;

    logic [2:0]     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [RCW-1:0] rc_q, rc_d;
    logic [7:0]     llc_q, llc_d;
    logic           mmcm_q, sys_q, ready_q, fault_q;
    logic           fail;

    assign locked_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        rc_d    = rc_q;
        llc_d   = llc_q;
        fail    = 1'b0;

        case (state_q)
            S_RST_HOLD: begin
                if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (locked_s)               state_d = S_SETTLE;
                else if (cnt_q == TO_LAST)  fail = 1'b1;
            end
            S_SETTLE: begin
                // a completion only counts if lock is still present
                if (!locked_s)              fail = 1'b1;
                else if (cnt_q == SET_LAST) state_d = S_RUN;
            end
            S_RUN: begin
                cnt_d = cnt_q;
                if (!locked_s) begin
                    if (llc_q != 8'hFF) llc_d = llc_q + 8'd1;
`ifdef MMCM_AUTO_RELOCK_EN
                    state_d = S_RST_HOLD;
                    rc_d    = '0;
`else
                    state_d = S_FAULT;
`endif
                end
            end
            S_FAULT: begin
                cnt_d = cnt_q;
            end
            default: begin
                state_d = S_RST_HOLD;
            end
        endcase

        if (fail) begin
            if (rc_q < RC_MAX) begin
                rc_d    = rc_q + 1'b1;
                state_d = S_RST_HOLD;
            end else begin
                state_d = S_FAULT;
            end
        end

        // restart overrides whatever the state wanted this cycle
        if (restart) begin
            state_d = S_RST_HOLD;
            rc_d    = '0;
        end

        // counter restarts on every state entry, including re-entry
        if (restart || (state_d != state_q)) cnt_d = '0;
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            sync_q  <= '0;
            state_q <= S_RST_HOLD;
            cnt_q   <= '0;
            rc_q    <= '0;
            llc_q   <= '0;
            mmcm_q  <= 1'b1;
            sys_q   <= 1'b1;
            ready_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], locked};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rc_q    <= rc_d;
            llc_q   <= llc_d;
            // outputs decoded from the next state so they are registered
            mmcm_q  <= (state_d == S_RST_HOLD) || (state_d == S_FAULT);
            sys_q   <= (state_d != S_RUN);
            ready_q <= (state_d == S_RUN);
            fault_q <= (state_d == S_FAULT);
        end
    end

    assign mmcm_rst      = mmcm_q;
    assign sys_rst       = sys_q;
    assign ready         = ready_q;
    assign fault         = fault_q;
    assign retry_count   = rc_q;
    assign lock_loss_cnt = llc_q;

endmodule
